// File: rtl/float_to_fixed_param.sv
// float_to_fixed_param
// Converts an IEEE-754 single-precision operand into a signed W_OUT-bit
// fixed-point number with FRAC fraction bits (RESULT = F * 2^FRAC).
// A small control FSM runs the conversion through three pipeline-like
// phases (ALIGN, ROUND, SAT) and then holds the answer in DONE until the
// start request is dropped.
//
// Ports
//   CLK           system clock, rising edge
//   RST_FF        synchronous active-high reset of everything
//   RST_FSM_FF    synchronous active-high soft reset of the control FSM only
//   Begin_FSM_FF  start request, level-sampled in IDLE
//   F             single-precision operand, captured at the start edge
//   RND_MODE      0 = truncate toward zero, 1 = round to nearest, ties away
//   RESULT        signed fixed-point result
//   ACK_FF        conversion done, RESULT and flags valid
//   BUSY          conversion in progress (ALIGN, ROUND, SAT)
//   OVF/UNF/INV   saturation, underflow-to-zero and NaN flags
module float_to_fixed_param #(
    parameter int W_OUT = 32,
    parameter int FRAC  = 26
) (
    input  logic             CLK,
    input  logic             RST_FF,
    input  logic             RST_FSM_FF,
    input  logic             Begin_FSM_FF,
    input  logic [31:0]      F,
    input  logic             RND_MODE,
    output logic [W_OUT-1:0] RESULT,
    output logic             ACK_FF,
    output logic             BUSY,
    output logic             OVF,
    output logic             UNF,
    output logic             INV
);

    // Internal magnitude width: wide enough for the 24-bit significand and
    // for any in-range result, plus headroom so that a rounding carry and a
    // value just above the saturation limit are both still representable.
    localparam int MW      = ((W_OUT > 24) ? W_OUT : 24) + 2;
    // A left shift at or beyond this distance puts the leading one at bit
    // MW-1 or higher, which is always far above the saturation limit.
    localparam int LSH_BIG = MW - 24;
    // A right shift at or beyond this distance pushes every significand bit
    // below the guard position, so everything becomes sticky.
    localparam int RSH_ALL = 48;

    localparam logic [MW-1:0]    LIM_POS = {{(MW-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic [MW-1:0]    LIM_NEG = {{(MW-W_OUT){1'b0}}, 1'b1, {(W_OUT-1){1'b0}}};
    localparam logic [W_OUT-1:0] SAT_POS = {1'b0, {(W_OUT-1){1'b1}}};
    localparam logic [W_OUT-1:0] SAT_NEG = {1'b1, {(W_OUT-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ROUND,
        S_SAT,
        S_DONE
    } state_t;

    state_t           state_q,  state_d;
    logic [31:0]      f_q,      f_d;
    logic             rnd_q,    rnd_d;
    logic [MW-1:0]    mag_q,    mag_d;
    logic             guard_q,  guard_d;
    logic             sticky_q, sticky_d;
    logic             big_q,    big_d;
    logic [W_OUT-1:0] result_q, result_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic             inv_q,    inv_d;

    logic             f_sign;
    logic [7:0]       f_exp;
    logic [22:0]      f_man;
    logic [23:0]      m24;
    int               sh;
    int               rsh;
    logic [MW-1:0]    lsh_val;
    logic [47:0]      rsh_ext;
    logic [W_OUT-1:0] neg_mag;

    // Operand decode and the two candidate alignments. The captured operand
    // is used throughout so later changes on F cannot disturb a conversion.
    always_comb begin
        f_sign  = f_q[31];
        f_exp   = f_q[30:23];
        f_man   = f_q[22:0];
        m24     = {1'b1, f_man};
        sh      = int'(f_exp) - 150 + FRAC;
        rsh     = -sh;
        lsh_val = {{(MW-24){1'b0}}, m24} << 7'(sh);
        // Significand placed above 24 zero bits: after the right shift the
        // top half is the integer magnitude, bit 23 is the guard bit and the
        // rest collapses into sticky.
        rsh_ext = {m24, 24'b0} >> 6'(rsh);
        neg_mag = ~mag_q[W_OUT-1:0] + {{(W_OUT-1){1'b0}}, 1'b1};
    end

    // Next-state and datapath update for every stage of the conversion.
    always_comb begin
        state_d  = state_q;
        f_d      = f_q;
        rnd_d    = rnd_q;
        mag_d    = mag_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        big_d    = big_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inv_d    = inv_q;

        case (state_q)
            S_IDLE: begin
                if (Begin_FSM_FF) begin
                    f_d     = F;
                    rnd_d   = RND_MODE;
                    state_d = S_ALIGN;
                end
            end

            S_ALIGN: begin
                big_d    = 1'b0;
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                if (sh >= 0) begin
                    if (sh >= LSH_BIG) begin
                        big_d = 1'b1;
                        mag_d = '0;
                    end else begin
                        mag_d = lsh_val;
                    end
                end else if (rsh >= RSH_ALL) begin
                    mag_d    = '0;
                    sticky_d = 1'b1;
                end else begin
                    mag_d    = {{(MW-24){1'b0}}, rsh_ext[47:24]};
                    guard_d  = rsh_ext[23];
                    sticky_d = |rsh_ext[22:0];
                end
                state_d = S_ROUND;
            end

            S_ROUND: begin
                // Ties-away rounding on a magnitude only needs the guard bit;
                // sticky is kept to tell underflow apart from a true zero.
                mag_d   = mag_q + {{(MW-1){1'b0}}, rnd_q & guard_q};
                state_d = S_SAT;
            end

            S_SAT: begin
                if (!RST_FSM_FF) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inv_d    = 1'b0;
                    if (&f_exp) begin
                        if (|f_man) begin
                            inv_d = 1'b1;
                        end else begin
                            result_d = f_sign ? SAT_NEG : SAT_POS;
                            ovf_d    = 1'b1;
                        end
                    end else if (f_exp == 8'd0) begin
                        unf_d = |f_man;
                    end else if (big_q || (mag_q > (f_sign ? LIM_NEG : LIM_POS))) begin
                        result_d = f_sign ? SAT_NEG : SAT_POS;
                        ovf_d    = 1'b1;
                    end else if (mag_q == '0) begin
                        unf_d = guard_q | sticky_q;
                    end else begin
                        result_d = f_sign ? neg_mag : mag_q[W_OUT-1:0];
                    end
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                if (!Begin_FSM_FF) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (RST_FSM_FF) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers; the hard reset wins over everything.
    always_ff @(posedge CLK) begin
        if (RST_FF) begin
            state_q  <= S_IDLE;
            f_q      <= '0;
            rnd_q    <= 1'b0;
            mag_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            big_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            f_q      <= f_d;
            rnd_q    <= rnd_d;
            mag_q    <= mag_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            big_q    <= big_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inv_q    <= inv_d;
        end
    end

    assign RESULT = result_q;
    assign OVF    = ovf_q;
    assign UNF    = unf_q;
    assign INV    = inv_q;
    assign ACK_FF = (state_q == S_DONE);
    assign BUSY   = (state_q == S_ALIGN) || (state_q == S_ROUND) || (state_q == S_SAT);

endmodule

// File: tb/tb_float_to_fixed_param.sv
// tb_float_to_fixed_param
// Directed bench for float_to_fixed_param at its default width (W_OUT=32,
// FRAC=26). Expected results are hand-computed fixed-point values.
module tb_float_to_fixed_param;

    logic        CLK;
    logic        RST_FF;
    logic        RST_FSM_FF;
    logic        Begin_FSM_FF;
    logic [31:0] F;
    logic        RND_MODE;
    logic [31:0] RESULT;
    logic        ACK_FF;
    logic        BUSY;
    logic        OVF;
    logic        UNF;
    logic        INV;

    int          checks;
    int          errors;
    logic [31:0] lastExp;

    float_to_fixed_param #(
        .W_OUT(32),
        .FRAC (26)
    ) dut (
        .CLK         (CLK),
        .RST_FF      (RST_FF),
        .RST_FSM_FF  (RST_FSM_FF),
        .Begin_FSM_FF(Begin_FSM_FF),
        .F           (F),
        .RND_MODE    (RND_MODE),
        .RESULT      (RESULT),
        .ACK_FF      (ACK_FF),
        .BUSY        (BUSY),
        .OVF         (OVF),
        .UNF         (UNF),
        .INV         (INV)
    );

    // Free-running 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a conversion and waits for ACK_FF with a bounded edge count.
    // The operand is scrambled right after the start edge, and RESULT must
    // still show the previous answer while the FSM sits in SAT.
    task automatic applyStimulus(input logic [31:0] f, input logic rnd);
        int edges;
        edges = 0;
        @(negedge CLK);
        F            = f;
        RND_MODE     = rnd;
        Begin_FSM_FF = 1'b1;
        do begin
            @(posedge CLK);
            #1;
            edges++;
            if (edges == 1) begin
                checkOutput("busy_after_start", {63'b0, BUSY}, 64'd1);
                F        = $urandom;
                RND_MODE = ~rnd;
            end
            if (edges == 3) begin
                checkOutput("result_hold_in_sat", {32'b0, RESULT}, {32'b0, lastExp});
            end
        end while (!ACK_FF && edges < 20);
        checkOutput("ack_latency", 64'(edges), 64'd4);
    endtask

    // Compares RESULT and the {OVF,UNF,INV} flags after a conversion.
    task automatic checkConv(input string tag, input logic [31:0] expRes, input logic [2:0] expFlags);
        checkOutput({tag, "_result"}, {32'b0, RESULT}, {32'b0, expRes});
        checkOutput({tag, "_flags"}, {61'b0, OVF, UNF, INV}, {61'b0, expFlags});
        lastExp = expRes;
    endtask

    // Drops the start request so DONE returns to IDLE.
    task automatic releaseBegin();
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("ack_drop", {63'b0, ACK_FF}, 64'd0);
    endtask

    task automatic runVector(input string tag, input logic [31:0] f, input logic rnd,
                             input logic [31:0] expRes, input logic [2:0] expFlags);
        applyStimulus(f, rnd);
        checkConv(tag, expRes, expFlags);
        releaseBegin();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        lastExp      = 32'h0;
        RST_FF       = 1'b1;
        RST_FSM_FF   = 1'b0;
        Begin_FSM_FF = 1'b0;
        F            = 32'h0;
        RND_MODE     = 1'b0;

        // Reset state.
        @(posedge CLK);
        @(posedge CLK);
        #1;
        checkOutput("reset_result", {32'b0, RESULT}, 64'd0);
        checkOutput("reset_ctrl", {59'b0, ACK_FF, BUSY, OVF, UNF, INV}, 64'd0);
        @(negedge CLK);
        RST_FF = 1'b0;

        // Plain values and saturation boundaries.
        runVector("one",        32'h3F800000, 1'b0, 32'h04000000, 3'b000);
        runVector("minus_one",  32'hBF800000, 1'b0, 32'hFC000000, 3'b000);
        runVector("hundred",    32'h42C80000, 1'b0, 32'h7FFFFFFF, 3'b100);
        runVector("minus_32",   32'hC2000000, 1'b0, 32'h80000000, 3'b000);
        runVector("plus_32",    32'h42000000, 1'b0, 32'h7FFFFFFF, 3'b100);
        runVector("below_m32",  32'hC2000001, 1'b0, 32'h80000000, 3'b100);
        runVector("minus_half", 32'hBF000000, 1'b0, 32'hFE000000, 3'b000);
        runVector("three_3",    32'h40533333, 1'b0, 32'h0D333330, 3'b000);

        // Rounding and underflow.
        runVector("tiny_trunc", 32'h32000000, 1'b0, 32'h00000000, 3'b010);
        runVector("tiny_round", 32'h32000000, 1'b1, 32'h00000001, 3'b000);
        runVector("tie_trunc",  32'h32C00000, 1'b0, 32'h00000001, 3'b000);
        runVector("tie_round",  32'h32C00000, 1'b1, 32'h00000002, 3'b000);
        runVector("ntie_trunc", 32'hB2C00000, 1'b0, 32'hFFFFFFFF, 3'b000);
        runVector("ntie_round", 32'hB2C00000, 1'b1, 32'hFFFFFFFE, 3'b000);
        runVector("min_normal", 32'h00800000, 1'b1, 32'h00000000, 3'b010);
        runVector("huge_exp",   32'h7F000000, 1'b0, 32'h7FFFFFFF, 3'b100);

        // Special encodings.
        runVector("nan",        32'h7FC00000, 1'b0, 32'h00000000, 3'b001);
        runVector("neg_inf",    32'hFF800000, 1'b0, 32'h80000000, 3'b100);
        runVector("pos_inf",    32'h7F800000, 1'b0, 32'h7FFFFFFF, 3'b100);
        runVector("zero",       32'h00000000, 1'b0, 32'h00000000, 3'b000);
        runVector("neg_zero",   32'h80000000, 1'b0, 32'h00000000, 3'b000);
        runVector("denormal",   32'h00000001, 1'b0, 32'h00000000, 3'b010);

        // Begin held high through DONE must not retrigger.
        applyStimulus(32'h3F800000, 1'b0);
        checkConv("held_first", 32'h04000000, 3'b000);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            checkOutput("held_ack", {62'b0, ACK_FF, BUSY}, 64'd2);
        end
        releaseBegin();
        runVector("second_conv", 32'h40000000, 1'b0, 32'h08000000, 3'b000);

        // Hard reset in ROUND, with Begin still high.
        @(negedge CLK);
        F            = 32'hBF800000;
        RND_MODE     = 1'b0;
        Begin_FSM_FF = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        checkOutput("round_busy", {63'b0, BUSY}, 64'd1);
        @(negedge CLK);
        RST_FF = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("rst_round_result", {32'b0, RESULT}, 64'd0);
        checkOutput("rst_round_ctrl", {59'b0, ACK_FF, BUSY, OVF, UNF, INV}, 64'd0);
        @(negedge CLK);
        RST_FF       = 1'b0;
        Begin_FSM_FF = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("after_rst_idle", {62'b0, ACK_FF, BUSY}, 64'd0);
        lastExp = 32'h0;

        // First start after reset, then soft reset in DONE.
        applyStimulus(32'h3F800000, 1'b0);
        checkConv("post_reset", 32'h04000000, 3'b000);
        @(negedge CLK);
        RST_FSM_FF = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("soft_rst_ctrl", {62'b0, ACK_FF, BUSY}, 64'd0);
        checkOutput("soft_rst_result", {32'b0, RESULT}, 64'h04000000);
        @(negedge CLK);
        RST_FSM_FF   = 1'b0;
        Begin_FSM_FF = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("soft_rst_idle", {62'b0, ACK_FF, BUSY}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_to_fixed_param.md
FLOAT_TO_FIXED_PARAM -- requirements
Module: float_to_fixed_param

Interface
REQ-001 SHALL have parameter W_OUT, default 32, signed two's-complement output width; legal range 8..64.
REQ-002 SHALL have parameter FRAC, default 26, number of fraction bits in RESULT; legal range 0..W_OUT-1.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_FF  input  1  synchronous active-high reset.
REQ-005 SHALL have port RST_FSM_FF  input  1  synchronous active-high soft reset of the control FSM only.
REQ-006 SHALL have port Begin_FSM_FF  input  1  start request, level-sampled.
REQ-007 SHALL have port F  input  32  IEEE-754 single-precision operand.
REQ-008 SHALL have port RND_MODE  input  1  0 = truncate toward zero, 1 = round to nearest, ties away from zero.
REQ-009 SHALL have port RESULT  output  W_OUT  fixed-point result, value = F * 2^FRAC.
REQ-010 SHALL have port ACK_FF  output  1  conversion done, RESULT and flags valid.
REQ-011 SHALL have port BUSY  output  1  high in ALIGN, ROUND and SAT.
REQ-012 SHALL have ports OVF, UNF, INV  output  1 each  saturation, underflow-to-zero and NaN flags.

Function
REQ-013 FSM SHALL have states IDLE, ALIGN, ROUND, SAT, DONE.
REQ-014 In IDLE, Begin_FSM_FF=1 at an edge SHALL capture F and RND_MODE and move to ALIGN; later changes to F or RND_MODE SHALL NOT affect the current conversion.
REQ-015 Transitions ALIGN->ROUND->SAT->DONE SHALL be unconditional, one per cycle; ACK_FF SHALL rise 4 edges after the start edge (start edge counts as 1).
REQ-016 In DONE, ACK_FF SHALL stay 1 and RESULT and flags SHALL hold; the FSM SHALL return to IDLE on the first edge with Begin_FSM_FF=0. A held-high Begin SHALL NOT retrigger.
REQ-017 ALIGN: sh = E - 127 + FRAC - 23, where E is the exponent and M = {1,mantissa} is 24 bits. sh >= 0 SHALL left-shift M; sh < 0 SHALL right-shift M by -sh and keep guard and sticky bits.
REQ-018 ROUND: RND_MODE=1 with guard=1 SHALL increment the magnitude; RND_MODE=0 SHALL discard guard and sticky.
REQ-019 SAT (positive input): a magnitude above 2^(W_OUT-1)-1 SHALL give RESULT=2^(W_OUT-1)-1 and OVF=1.
REQ-020 SAT (negative input): a magnitude above 2^(W_OUT-1) SHALL give RESULT=-2^(W_OUT-1) and OVF=1. A magnitude exactly 2^(W_OUT-1) SHALL be exact with OVF=0.
REQ-021 The SAT stage SHALL apply the sign by two's-complement negation after rounding.
REQ-022 E=0 (zero or denormal) SHALL give RESULT=0. UNF SHALL be 1 only when the mantissa is nonzero.
REQ-023 A normal nonzero input that rounds to magnitude 0 SHALL give UNF=1.
REQ-024 E=255 with mantissa 0 (infinity) SHALL saturate per sign with OVF=1.
REQ-025 E=255 with mantissa nonzero (NaN) SHALL give RESULT=0 and INV=1.
REQ-026 Shift distances beyond the datapath width SHALL be detected as overflow (left) or as all-sticky (right); the shift itself SHALL NOT wrap.
REQ-027 RESULT and the flags SHALL update only on the SAT->DONE edge.
REQ-028 Flags SHALL be mutually exclusive.
REQ-029 RST_FSM_FF=1 SHALL force IDLE and set ACK_FF=0 and BUSY=0 on the next edge; RESULT and flags SHALL keep their values.

Reset
REQ-030 RST_FF=1 SHALL, on the next edge, set state=IDLE and RESULT=0, and set ACK_FF, BUSY, OVF, UNF and INV to 0.
REQ-031 RST_FF SHALL take priority over RST_FSM_FF and Begin_FSM_FF in any state, including mid-conversion.
REQ-032 After reset is released, the first start SHALL behave per REQ-014.

Verification (defaults W_OUT=32, FRAC=26)
REQ-033 F=0x3F800000, RND_MODE=0 -> RESULT=0x04000000, all flags 0, ACK_FF high on 4th edge.
REQ-034 F=0xBF800000 -> RESULT=0xFC000000; F=0x42C80000 (100.0) -> 0x7FFFFFFF with OVF=1; F=0xC2000000 (-32.0) -> 0x80000000 with OVF=0.
REQ-035 F=0x32000000 (2^-27): RND_MODE=0 -> 0x00000000 with UNF=1; RND_MODE=1 -> 0x00000001 with UNF=0.
REQ-036 F=0x7FC00000 -> RESULT=0 with INV=1; F=0xFF800000 -> 0x80000000 with OVF=1.
REQ-037 Begin held high through DONE -> exactly one conversion; Begin low for 1 cycle then high -> second conversion with new F.
REQ-038 RST_FF pulsed in ROUND -> next edge all outputs 0 and state IDLE. RST_FSM_FF pulsed in DONE -> ACK_FF=0 and RESULT retained.
